// File: rtl/fft_engine.sv
// fft_engine: N-point radix-2 DIT FFT/IFFT coprocessor, in place, one butterfly per clock.
// Samples load into bit-reversed slots so results export in natural order.
module fft_engine #(
   parameter int DW    = 32,
   parameter int LOG2N = 3,    // 2..4
   parameter int TW_W  = 16,   // Q2.(TW_W-2), at most 31
   parameter int SCALE = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic signed [DW-1:0] load_re,
   input  logic signed [DW-1:0] load_im,
   input  logic                 start,
   input  logic                 inverse,
   output logic                 busy,
   output logic                 done,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [DW-1:0] out_re,
   output logic signed [DW-1:0] out_im,
   output logic                 out_last
);
   // state | meaning
   // LOAD  | accepting N samples, sample k stored at bitrev(k)
   // READY | array full, waiting for start
   // CALC  | one butterfly per cycle, LOG2N stages of N/2
   // OUT   | exporting array[0..N-1] in natural order

   localparam int N    = 1 << LOG2N;
   localparam int HALF = N / 2;
   localparam int BW   = LOG2N - 1;
   localparam int FB   = TW_W - 2;
   localparam int DW1  = DW + 1;
   localparam int PW   = DW + TW_W + 1;
   localparam int SH   = 32 - TW_W;
   localparam int SSH  = (SCALE != 0) ? 1 : 0;
   localparam logic signed [32:0] RND = 33'sd1 <<< (SH - 1);

   typedef enum logic [1:0] {S_LOAD, S_READY, S_CALC, S_OUT} state_t;

   state_t               state, state_nx;
   logic [LOG2N-1:0]     idx;
   logic [1:0]           stage;
   logic [BW-1:0]        bfly;
   logic                 inv_q;
   logic                 last_bfly;

   logic signed [DW-1:0] mem_re [N];
   logic signed [DW-1:0] mem_im [N];

   logic [LOG2N-1:0]     b_ext, half_dist, pos_mask, pos, addr_a, addr_b;
   logic [2:0]           tw_idx;
   logic signed [31:0]   cos_q30, sin_q30;
   logic signed [TW_W-1:0] w_re, w_im, sin_tw;
   logic signed [DW-1:0] a_re, a_im, b_re, b_im;
   logic signed [PW-1:0] p_re, p_im;
   logic signed [DW1-1:0] t_re, t_im, sa_re, sa_im, sb_re, sb_im;
   logic signed [DW-1:0] na_re, na_im, nb_re, nb_im;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
      return r;
   endfunction

   // Round a Q2.30 table entry to Q2.(TW_W-2).
   function automatic logic signed [TW_W-1:0] tw_q(input logic signed [31:0] v);
      logic signed [32:0] r;
      r = 33'(v) + RND;
      return TW_W'(r >>> SH);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_LOAD;
      else        state <= state_nx;
   end

   assign last_bfly = (stage == 2'(LOG2N - 1)) && (bfly == BW'(HALF - 1));

   always_comb begin
      state_nx = state;
      if (clear) begin
         state_nx = S_LOAD;
      end else begin
         case (state)
            S_LOAD:  if (load_valid && idx == LOG2N'(N - 1)) state_nx = S_READY;
            S_READY: if (start) state_nx = S_CALC;
            S_CALC:  if (last_bfly) state_nx = S_OUT;
            S_OUT:   if (out_ready && idx == LOG2N'(N - 1)) state_nx = S_LOAD;
            default: state_nx = S_LOAD;
         endcase
      end
   end

   always_comb begin
      load_ready = (state == S_LOAD);
      busy       = (state == S_CALC);
      done       = (state == S_CALC) && last_bfly;
      out_valid  = (state == S_OUT);
      out_last   = (state == S_OUT) && (idx == LOG2N'(N - 1));
      out_re     = (state == S_OUT) ? mem_re[idx] : '0;
      out_im     = (state == S_OUT) ? mem_im[idx] : '0;
   end

   // idx counts load beats, then export beats; it wraps to 0 after N-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx   <= '0;
         stage <= '0;
         bfly  <= '0;
         inv_q <= 1'b0;
      end else if (clear) begin
         idx   <= '0;
         stage <= '0;
         bfly  <= '0;
      end else begin
         case (state)
            S_LOAD:  if (load_valid) idx <= idx + LOG2N'(1);
            S_READY: if (start) begin
                        inv_q <= inverse;
                        stage <= '0;
                        bfly  <= '0;
                     end
            S_CALC:  if (bfly == BW'(HALF - 1)) begin
                        bfly  <= '0;
                        stage <= stage + 2'd1;
                     end else begin
                        bfly  <= bfly + BW'(1);
                     end
            S_OUT:   if (out_ready) idx <= idx + LOG2N'(1);
            default: ;
         endcase
      end
   end

   always_comb begin
      b_ext     = LOG2N'(bfly);
      half_dist = LOG2N'(1) << stage;
      pos_mask  = half_dist - LOG2N'(1);
      pos       = b_ext & pos_mask;
      addr_a    = ((b_ext & ~pos_mask) << 1) | pos;
      addr_b    = addr_a | half_dist;
      // index into the 16-point table: pos * N/2^(s+1) * 16/N
      tw_idx    = 3'(8'(pos) << (2'd3 - stage));
   end

   always_comb begin
      cos_q30 = 32'sd0;
      sin_q30 = 32'sd0;
      case (tw_idx)
         3'd0: begin cos_q30 =  32'sd1073741824; sin_q30 = 32'sd0;          end
         3'd1: begin cos_q30 =  32'sd992008094;  sin_q30 = 32'sd410903207;  end
         3'd2: begin cos_q30 =  32'sd759250125;  sin_q30 = 32'sd759250125;  end
         3'd3: begin cos_q30 =  32'sd410903207;  sin_q30 = 32'sd992008094;  end
         3'd4: begin cos_q30 =  32'sd0;          sin_q30 = 32'sd1073741824; end
         3'd5: begin cos_q30 = -32'sd410903207;  sin_q30 = 32'sd992008094;  end
         3'd6: begin cos_q30 = -32'sd759250125;  sin_q30 = 32'sd759250125;  end
         3'd7: begin cos_q30 = -32'sd992008094;  sin_q30 = 32'sd410903207;  end
         default: ;
      endcase
   end

   always_comb begin
      w_re   = tw_q(cos_q30);
      sin_tw = tw_q(sin_q30);
      w_im   = inv_q ? sin_tw : -sin_tw;
      a_re   = mem_re[addr_a];
      a_im   = mem_im[addr_a];
      b_re   = mem_re[addr_b];
      b_im   = mem_im[addr_b];
      p_re   = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
      p_im   = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
      t_re   = DW1'(p_re >>> FB);
      t_im   = DW1'(p_im >>> FB);
      sa_re  = DW1'(a_re) + t_re;
      sa_im  = DW1'(a_im) + t_im;
      sb_re  = DW1'(a_re) - t_re;
      sb_im  = DW1'(a_im) - t_im;
      na_re  = DW'(sa_re >>> SSH);
      na_im  = DW'(sa_im >>> SSH);
      nb_re  = DW'(sb_re >>> SSH);
      nb_im  = DW'(sb_im >>> SSH);
   end

   // Sample array is deliberately not reset.
   always_ff @(posedge clk) begin
      if (!clear) begin
         if (state == S_LOAD && load_valid) begin
            mem_re[bitrev(idx)] <= load_re;
            mem_im[bitrev(idx)] <= load_im;
         end else if (state == S_CALC) begin
            mem_re[addr_a] <= na_re;
            mem_im[addr_a] <= na_im;
            mem_re[addr_b] <= nb_re;
            mem_im[addr_b] <= nb_im;
         end
      end
   end

endmodule

// File: tb/tb_fft_engine.sv
// tb_fft_engine: drives an unscaled and a scaled engine in lockstep, checks against
// hand-derived vectors and a behavioural FFT model.
module tb_fft_engine;
   localparam int DW = 32;
   localparam int LOG2N = 3;
   localparam int N = 8;
   localparam int TW_W = 16;

   logic clk = 1'b0;
   logic rst_n, clear, load_valid, start, inverse, out_ready;
   logic signed [DW-1:0] load_re, load_im;
   logic load_ready [2];
   logic busy [2];
   logic done [2];
   logic out_valid [2];
   logic out_last [2];
   logic signed [DW-1:0] out_re [2];
   logic signed [DW-1:0] out_im [2];

   always #5 clk = ~clk;

   fft_engine #(.DW(DW), .LOG2N(LOG2N), .TW_W(TW_W), .SCALE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .load_valid(load_valid),
      .load_ready(load_ready[0]), .load_re(load_re), .load_im(load_im),
      .start(start), .inverse(inverse), .busy(busy[0]), .done(done[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready), .out_re(out_re[0]),
      .out_im(out_im[0]), .out_last(out_last[0]));

   fft_engine #(.DW(DW), .LOG2N(LOG2N), .TW_W(TW_W), .SCALE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .load_valid(load_valid),
      .load_ready(load_ready[1]), .load_re(load_re), .load_im(load_im),
      .start(start), .inverse(inverse), .busy(busy[1]), .done(done[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready), .out_re(out_re[1]),
      .out_im(out_im[1]), .out_last(out_last[1]));

   typedef struct packed {
      logic [N-1:0][DW-1:0] x_re;
      logic [N-1:0][DW-1:0] x_im;
      logic [N-1:0][DW-1:0] e_re;
      logic [N-1:0][DW-1:0] e_im;
      int inv;
      int sel;
      int tol;
      int bp;
   } vec_t;

   vec_t   vecs [5];
   int     sh_re [N] = '{1000, 707, 0, -707, -1000, -707, 0, 707};
   int     sh_im [N] = '{0, -707, -1000, -707, 0, 707, 1000, 707};
   longint tw_c [16];
   longint tw_s [16];
   longint cur_re [N];
   longint cur_im [N];
   longint got_re [2][N];
   longint got_im [2][N];
   longint exp_re [2][N];
   longint exp_im [2][N];
   int     n_vec = 0;
   int     n_err = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bit(input string nm, input int d, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %b, want %b", nm, d, act, exp);
      end
   endtask

   task automatic check_val(input string nm, input int d, input int k, input longint act,
                            input longint exp, input int tol);
      longint diff;
      n_vec++;
      diff = act - exp;
      if (diff < -tol || diff > tol) begin
         n_err++;
         $display("FAIL %s dut%0d[%0d]: got %0d, want %0d (tol %0d)", nm, d, k, act, exp, tol);
      end
   endtask

   function automatic int rev3(input int k);
      return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
   endfunction

   function automatic longint fit(input longint v, input int sc);
      return longint'(int'((sc != 0) ? (v >>> 1) : v));
   endfunction

   // Textbook iterative DIT FFT over the bit-reversed input, fixed-point twiddles.
   task automatic model(input bit inv);
      longint ar [N];
      longint ai [N];
      longint wr, wi, br, bi, tr, ti, xr, xi;
      int m, span;
      for (int sc = 0; sc < 2; sc++) begin
         for (int k = 0; k < N; k++) begin
            ar[rev3(k)] = cur_re[k];
            ai[rev3(k)] = cur_im[k];
         end
         span = 1;
         while (span < N) begin
            for (int g = 0; g < N; g += 2 * span) begin
               for (int p = 0; p < span; p++) begin
                  m  = p * (N / (2 * span));
                  wr = tw_c[2 * m];
                  wi = inv ? tw_s[2 * m] : -tw_s[2 * m];
                  br = ar[g + p + span];
                  bi = ai[g + p + span];
                  tr = (br * wr - bi * wi) >>> (TW_W - 2);
                  ti = (br * wi + bi * wr) >>> (TW_W - 2);
                  xr = ar[g + p];
                  xi = ai[g + p];
                  ar[g + p]        = fit(xr + tr, sc);
                  ai[g + p]        = fit(xi + ti, sc);
                  ar[g + p + span] = fit(xr - tr, sc);
                  ai[g + p + span] = fit(xi - ti, sc);
               end
            end
            span = span * 2;
         end
         for (int k = 0; k < N; k++) begin
            exp_re[sc][k] = ar[k];
            exp_im[sc][k] = ai[k];
         end
      end
   endtask

   task automatic compare_model();
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < N; k++) begin
            check_val("model_re", d, k, got_re[d][k], exp_re[d][k], 0);
            check_val("model_im", d, k, got_im[d][k], exp_im[d][k], 0);
         end
      end
   endtask

   task automatic load_beats(input int first, input int cnt);
      for (int k = first; k < first + cnt; k++) begin
         for (int d = 0; d < 2; d++) check_bit("load_ready", d, load_ready[d], 1'b1);
         load_valid = 1'b1;
         load_re    = DW'(cur_re[k]);
         load_im    = DW'(cur_im[k]);
         tick();
      end
      load_valid = 1'b0;
   endtask

   task automatic do_calc(input bit inv, input bit with_load);
      int cnt [2];
      int dn [2];
      int dat [2];
      inverse    = inv;
      start      = 1'b1;
      load_valid = with_load;
      load_re    = 12345;
      load_im    = -321;
      tick();
      start      = 1'b0;
      load_valid = 1'b0;
      inverse    = ~inv;
      for (int d = 0; d < 2; d++) begin
         cnt[d] = 0;
         dn[d]  = 0;
         dat[d] = 0;
      end
      for (int c = 0; c < 40; c++) begin
         if (busy[0] !== 1'b1 && busy[1] !== 1'b1) break;
         for (int d = 0; d < 2; d++) begin
            if (busy[d] === 1'b1) cnt[d]++;
            if (done[d] === 1'b1) begin
               dn[d]++;
               dat[d] = cnt[d];
            end
         end
         tick();
      end
      for (int d = 0; d < 2; d++) begin
         check_val("calc_cycles", d, 0, cnt[d], 12, 0);
         check_val("done_pulses", d, 0, dn[d], 1, 0);
         check_val("done_cycle", d, 0, dat[d], 12, 0);
         check_bit("done_low", d, done[d], 1'b0);
      end
   endtask

   task automatic do_out(input int bp_at);
      for (int j = 0; j < N; j++) begin
         for (int d = 0; d < 2; d++) begin
            check_bit("out_valid", d, out_valid[d], 1'b1);
            check_bit("out_last", d, out_last[d], j == N - 1);
            got_re[d][j] = longint'(out_re[d]);
            got_im[d][j] = longint'(out_im[d]);
         end
         if (j == bp_at) begin
            out_ready = 1'b0;
            start     = 1'b1;
            repeat (3) begin
               tick();
               for (int d = 0; d < 2; d++) begin
                  check_bit("hold_valid", d, out_valid[d], 1'b1);
                  check_val("hold_re", d, j, longint'(out_re[d]), got_re[d][j], 0);
                  check_val("hold_im", d, j, longint'(out_im[d]), got_im[d][j], 0);
                  check_bit("start_in_out", d, busy[d], 1'b0);
               end
            end
            start     = 1'b0;
            out_ready = 1'b1;
         end
         tick();
      end
      for (int d = 0; d < 2; d++) begin
         check_bit("out_done_valid", d, out_valid[d], 1'b0);
         check_bit("out_done_load", d, load_ready[d], 1'b1);
      end
   endtask

   task automatic run_full(input bit inv, input int bp_at);
      load_beats(0, N);
      for (int d = 0; d < 2; d++) check_bit("ready_state", d, load_ready[d], 1'b0);
      do_calc(inv, 1'b0);
      do_out(bp_at);
      model(inv);
      compare_model();
   endtask

   task automatic rand_data();
      for (int k = 0; k < N; k++) begin
         cur_re[k] = longint'($urandom_range(0, 1 << 20)) - (1 << 19);
         cur_im[k] = longint'($urandom_range(0, 1 << 20)) - (1 << 19);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 16; k++) begin
         tw_c[k] = longint'($rtoi($floor($cos(2.0 * 3.14159265358979 * k / 16.0) * 16384.0 + 0.5)));
         tw_s[k] = longint'($rtoi($floor($sin(2.0 * 3.14159265358979 * k / 16.0) * 16384.0 + 0.5)));
      end
      for (int i = 0; i < 5; i++) begin
         vecs[i]    = '0;
         vecs[i].bp = -1;
      end
      for (int k = 0; k < N; k++) begin
         vecs[0].e_re[k] = 1000;
         vecs[1].x_re[k] = 100;
         vecs[2].e_re[k] = sh_re[k];
         vecs[2].e_im[k] = sh_im[k];
         vecs[3].e_re[k] = 100;
      end
      vecs[0].x_re[0] = 1000;
      vecs[0].bp      = 2;
      vecs[1].e_re[0] = 800;
      vecs[2].x_re[1] = 1000;
      vecs[2].tol     = 1;
      vecs[3].x_re[0] = 800;
      vecs[3].inv     = 1;
      vecs[3].sel     = 1;
      vecs[4]         = vecs[2];

      rst_n = 1'b0; clear = 1'b0; load_valid = 1'b0; load_re = '0; load_im = '0;
      start = 1'b0; inverse = 1'b0; out_ready = 1'b1;
      #12;
      for (int d = 0; d < 2; d++) begin
         check_bit("rst_load_ready", d, load_ready[d], 1'b1);
         check_bit("rst_busy", d, busy[d], 1'b0);
         check_bit("rst_done", d, done[d], 1'b0);
         check_bit("rst_out_valid", d, out_valid[d], 1'b0);
         check_bit("rst_out_last", d, out_last[d], 1'b0);
         check_val("rst_out_re", d, 0, longint'(out_re[d]), 0, 0);
         check_val("rst_out_im", d, 0, longint'(out_im[d]), 0, 0);
      end
      #1 rst_n = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) begin
         for (int k = 0; k < N; k++) begin
            cur_re[k] = longint'($signed(vecs[i].x_re[k]));
            cur_im[k] = longint'($signed(vecs[i].x_im[k]));
         end
         run_full(vecs[i].inv != 0, vecs[i].bp);
         for (int k = 0; k < N; k++) begin
            check_val("vec_re", vecs[i].sel, k, got_re[vecs[i].sel][k],
                      longint'($signed(vecs[i].e_re[k])), vecs[i].tol);
            check_val("vec_im", vecs[i].sel, k, got_im[vecs[i].sel][k],
                      longint'($signed(vecs[i].e_im[k])), vecs[i].tol);
         end
      end

      // start after only N-1 loads is ignored
      rand_data();
      load_beats(0, N - 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int d = 0; d < 2; d++) begin
         check_bit("early_start_busy", d, busy[d], 1'b0);
         check_bit("early_start_load", d, load_ready[d], 1'b1);
      end
      load_beats(N - 1, 1);
      do_calc(1'b0, 1'b0);
      do_out(-1);
      model(1'b0);
      compare_model();

      // load_valid together with start in READY: no load, CALC entered
      rand_data();
      load_beats(0, N);
      do_calc(1'b1, 1'b1);
      do_out(-1);
      model(1'b1);
      compare_model();

      // async reset in CALC cycle 5
      rand_data();
      load_beats(0, N);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      for (int d = 0; d < 2; d++) check_bit("pre_rst_busy", d, busy[d], 1'b1);
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check_bit("midcalc_rst_busy", d, busy[d], 1'b0);
         check_bit("midcalc_rst_load", d, load_ready[d], 1'b1);
         check_bit("midcalc_rst_done", d, done[d], 1'b0);
      end
      #2 rst_n = 1'b1;
      tick();
      rand_data();
      run_full(1'b0, -1);

      // clear during OUT
      rand_data();
      load_beats(0, N);
      do_calc(1'b0, 1'b0);
      tick();
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int d = 0; d < 2; d++) begin
         check_bit("clear_out_valid", d, out_valid[d], 1'b0);
         check_bit("clear_out_last", d, out_last[d], 1'b0);
         check_bit("clear_load", d, load_ready[d], 1'b1);
         check_bit("clear_busy", d, busy[d], 1'b0);
      end
      rand_data();
      run_full(1'b1, -1);

      for (int r = 0; r < 6; r++) begin
         int bp;
         rand_data();
         bp = int'($urandom_range(0, N));
         if (bp == N) bp = -1;
         run_full($urandom_range(0, 1) != 0, bp);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fft_engine.md
Name: fft_engine

Overview:
- Parametrised N-point radix-2 decimation-in-time (DIT) FFT/IFFT coprocessor for the RISC-V datapath. It replaces the fixed 8-point, three-stage, unclocked butterfly chain.
- Samples stream in through a valid/ready load port and are stored in bit-reversed order in an internal register array.
- The transform runs in place, one butterfly per cycle, with a runtime forward/inverse mode and an optional per-stage scaling mode.
- Results stream out in natural order through a valid/ready export port. The ALU's FFT load, calculate and export ops drive these ports.

Parameters:
- DW, 32, sample width per real/imag component, signed two's complement.
- LOG2N, 3, log2 of point count; legal values 2..4 (N = 4, 8, 16).
- TW_W, 16, twiddle width; format Q2.(TW_W-2), so +1.0 = 2^(TW_W-2).
- SCALE, 0, 1 = arithmetic shift right by 1 after every stage (total 1/N); 0 = no scaling, results wrap at DW.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush: return to LOAD, count 0, from any state.
- load_valid  in  1  load beat present.
- load_ready  out  1  engine accepts a load beat.
- load_re  in  DW  real part of the load sample.
- load_im  in  DW  imaginary part of the load sample.
- start  in  1  begin transform; accepted only in READY.
- inverse  in  1  sampled with start; 1 = IFFT (conjugate twiddles).
- busy  out  1  high in CALC.
- done  out  1  one-cycle pulse on the cycle CALC exits.
- out_valid  out  1  export beat present.
- out_ready  in  1  consumer accepts the export beat.
- out_re  out  DW  real part of the export sample.
- out_im  out  DW  imaginary part of the export sample.
- out_last  out  1  marks sample index N-1.

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD; all counters 0.
  - load_ready=1; busy=0; done=0; out_valid=0; out_last=0; out_re=0; out_im=0.
  - Sample array is not cleared.
- States: LOAD -> READY -> CALC -> OUT -> LOAD.
- LOAD:
  - load_ready=1.
  - A beat transfers when load_valid&&load_ready. Sample k is written to address bitrev(k, LOG2N).
  - After beat N-1 the state moves to READY.
  - start in LOAD is ignored.
- READY:
  - load_ready=0.
  - start=1 latches inverse, clears stage/butterfly counters, and moves to CALC.
  - A load_valid presented in the same cycle is not accepted.
- CALC:
  - busy=1.
  - Per stage s=0..LOG2N-1, butterflies b=0..N/2-1, one per cycle. Operands are read combinationally and results written at the clock edge.
  - Butterfly pair distance is 2^s. Twiddle index is (b mod 2^s) * (N / 2^(s+1)) into an N/2-entry table of W_N^k = cos(2πk/N) - j·sin(2πk/N), stored as TW_W-bit constants for N=16 and strided for smaller N.
  - inverse=1 negates the twiddle imaginary part.
  - Total CALC length is exactly LOG2N*N/2 cycles (N=8: 12 cycles).
  - On the final write, done=1 for that one cycle and the state moves to OUT.
- Arithmetic:
  - t = B·W as a full-precision product, then arithmetic shift right by TW_W-2 (floor).
  - A' = A + t and B' = A - t, computed at DW+1 bits.
  - SCALE=1: shift >>>1 into DW. SCALE=0: truncate to DW (wrap, no saturation).
- OUT:
  - out_valid=1, presenting array[j] for j=0..N-1. Natural order requires no reorder.
  - Data is held stable while out_valid&&!out_ready.
  - j advances on out_valid&&out_ready. out_last=1 when j=N-1.
  - The transfer of the last beat returns the state to LOAD, with out_valid=0 in the following cycle.
- clear:
  - Overrides all other inputs in the cycle it is high.
  - busy, done, out_valid and out_last drop in the next cycle; no partial result is exported.
- rst_n low mid-CALC or mid-OUT: immediate return to the reset state. A new load of N samples is required.
- No input signal is registered ahead of its use. Inputs are sampled at the clock edge only.

Test Plan:
- N=8, SCALE=0, forward: load x[0]=(1000,0), all others 0, start -> done exactly 12 cycles after start; all 8 outputs (1000,0); out_last only on the 8th beat.
- N=8, SCALE=0, forward: load x[n]=(100,0) for all n -> X[0]=(800,0), X[1..7]=(0,0).
- N=8, SCALE=0, forward: load x[1]=(1000,0), all others 0 -> X[0]=(1000,0), X[2]=(0,-1000), X[4]=(-1000,0), X[1]=(707,-707) within ±1 LSB.
- N=8, SCALE=1, inverse: load X[0]=(800,0), all others 0 -> all outputs (100,0); then re-run the impulse case to confirm inverse is re-latched per start.
- Backpressure: hold out_ready=0 for 3 cycles at j=2 -> out_re/out_im/out_valid stable; j=3 follows on release. A start pulsed during OUT is ignored.
- Boundaries:
  - start after only 7 loads -> ignored; busy stays 0.
  - load_valid and start high together in READY -> load not accepted, CALC entered.
  - rst_n=0 at CALC cycle 5 -> busy=0, load_ready=1 immediately.
  - clear during OUT -> out_valid=0 next cycle, LOAD with count 0.
